mac_accum: RTL
==============

Name: mac_accum

Overview:
Downstream stage of the registered 16x16 multiplier. Consumes the 32-bit unsigned product stream with a valid/ready handshake and sums a programmable number of consecutive products into a wide accumulator. It presents each completed sum on a valid/ready output port with a sticky overflow flag. The upstream wrapper drives in_valid one cycle after it applies operands, which aligns in_valid with the registered product.

Parameters:
PROD_W, 32, product width; matches the multiplier result width.
ACC_W, 40, accumulator and output width; must be >= PROD_W.
LEN_W, 8, width of the block-length field.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cfg_len  input  LEN_W  products per sum; sampled when a block's first product is accepted; 0 is treated as 1
in_valid  input  1  in_prod is valid
in_ready  output  1  block accepts a product this cycle
in_prod  input  PROD_W  unsigned product from the multiplier
out_valid  output  1  out_sum and out_ovf are valid
out_ready  input  1  downstream accepts the sum
out_sum  output  ACC_W  completed sum, modulo 2^ACC_W
out_ovf  output  1  set if any addition in the block carried out of ACC_W
busy  output  1  high in ACC or HOLD

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous assert and synchronous deassert (synchronised outside this block).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_ovf=0, busy=0. The internal accumulator, counter and latched length also clear to 0.
- Handshakes:
  - A product transfers on any cycle with in_valid && in_ready.
  - A sum transfers on any cycle with out_valid && out_ready.
  - in_ready is a registered state decode and does not depend on in_valid.
- State IDLE (in_ready=1):
  - On transfer: acc<=zero-extended in_prod, cnt<=1, len_q<=max(cfg_len,1), ovf<=0.
  - If len_q==1, go to HOLD; otherwise go to ACC.
- State ACC (in_ready=1):
  - On transfer: {carry,acc}<=acc+in_prod, ovf<=ovf|carry, cnt<=cnt+1.
  - If cnt+1==len_q, go to HOLD.
  - Cycles without in_valid leave all state unchanged (gaps are allowed).
- State HOLD (in_ready=0, out_valid=1):
  - out_sum=acc and out_ovf=ovf, both held stable while out_ready=0.
  - On transfer, go to IDLE.
- Latency: out_valid rises the cycle after the final product is accepted. There is exactly one in_ready-low bubble between blocks at minimum: the HOLD cycle(s), then IDLE.
- Counting and arithmetic:
  - cnt is LEN_W+1 bits wide, so len_q=2^LEN_W-1 causes no counter wrap.
  - The addition is unsigned. out_sum wraps modulo 2^ACC_W on overflow.
  - out_ovf is sticky within a block and cleared at the start of the next block.
  - With the defaults (ACC_W=40, at most 255 products of 2^32-1), out_ovf can never set.
- Boundary conditions:
  - cfg_len changing mid-block has no effect; only the first-product sample counts.
  - In HOLD, in_valid is ignored and no product is lost, because the source must hold it.
  - Reset asserted mid-block discards the partial sum immediately and returns all outputs to their reset values. No output pulse follows reset.

Test Plan:
- cfg_len=4, products 1,2,3,4 on consecutive cycles with out_ready=1 -> out_valid=1 for one cycle, starting the cycle after product 4; out_sum=10, out_ovf=0; in_ready=0 during that cycle.
- cfg_len=3, products 0x10,0x20,0x30 with 2-cycle in_valid gaps, out_ready=0 for 5 cycles -> out_sum=0x60 held stable, out_valid high all 5 cycles, in_ready=0; back to IDLE the cycle after out_ready=1.
- cfg_len=0 then cfg_len=1, product 0xFFFFFFFF each -> two sums, each 0xFFFFFFFF and each one cycle after its product; out_ovf=0.
- Override ACC_W=33, cfg_len=3, three products 0xFFFFFFFF -> out_sum=0x0FFFFFFFD, out_ovf=1. The next block (cfg_len=1, product 5) -> out_sum=5, out_ovf=0.
- cfg_len=4; accept 2 products (7,9); assert rst_n=0 asynchronously mid-cycle -> outputs reach reset values immediately. After release, a cfg_len=2 block with products 1,1 -> out_sum=2 (no residue of 16).
- Start a block with cfg_len=2, change cfg_len to 8 after the first product, products 100,200 -> out_sum=300 after 2 products.

Source files
------------

// File: rtl/mac_accum.sv
// ---------------------------------------------------------------------------
// mac_accum
//
// Accumulates a programmable number of consecutive unsigned products coming
// from the registered 16x16 multiplier and presents each completed sum on a
// valid/ready output port with a sticky carry-out (overflow) flag.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (deassertion synchronised outside)
//   cfg_len    products per sum, sampled with a block's first product; 0 -> 1
//   in_valid   in_prod carries a product
//   in_ready   block can accept a product this cycle (state decode only)
//   in_prod    unsigned product from the multiplier
//   out_valid  out_sum / out_ovf carry a completed block
//   out_ready  downstream accepts the completed block
//   out_sum    completed sum, modulo 2^ACC_W
//   out_ovf    some addition in the block carried out of ACC_W bits
//   busy       a block is in progress or waiting to be taken
// ---------------------------------------------------------------------------
module mac_accum #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    // One bit wider than the length so a full-length block never wraps.
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic [ACC_W:0]   prodExt;
    logic [ACC_W:0]   sumWide;
    logic [LEN_W:0]   cntInc;
    logic [LEN_W-1:0] lenEff;
    logic             inXfer;
    logic             outXfer;

    // Handshake decodes come straight from the registered state, so in_ready
    // never depends on in_valid.
    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

    assign inXfer  = in_valid && in_ready;
    assign outXfer = out_valid && out_ready;

    // Zero-extend the product to ACC_W+1 bits; the extra top bit of the sum
    // is the carry out of the accumulator.
    always_comb begin
        prodExt                 = '0;
        prodExt[PROD_W-1:0]     = in_prod;
    end

    assign sumWide = {1'b0, acc_q} + prodExt;
    assign cntInc  = cnt_q + 1'b1;
    // A zero length would never complete, so it is promoted to one.
    assign lenEff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

    // Next-state logic: start a block in IDLE, add products in ACC, and hold
    // the finished sum in HOLD until the downstream takes it.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (inXfer) begin
                    acc_d   = prodExt[ACC_W-1:0];
                    ovf_d   = 1'b0;
                    cnt_d   = LEN_W'(1) + (LEN_W+1)'(0);
                    len_d   = lenEff;
                    state_d = (lenEff == LEN_W'(1)) ? ST_HOLD : ST_ACC;
                end
            end
            ST_ACC: begin
                if (inXfer) begin
                    acc_d = sumWide[ACC_W-1:0];
                    ovf_d = ovf_q | sumWide[ACC_W];
                    cnt_d = cntInc;
                    if (cntInc == {1'b0, len_q}) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (outXfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any partial block immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

endmodule
